gpio_edge_irq: RTL and testbench

Input-side companion to the GPIO output controller. It samples 32 external input pins through a synchroniser and detects rising and falling edges per pin. Detected edges are latched into sticky, write-1-to-clear status bits, and a single level interrupt is raised towards the CPU. It sits on the same memory-mapped peripheral bus as the GPIO controller, with its own chip_select decode.

---
 rtl/gpio_edge_irq_pkg.sv | 18 +
 rtl/gpio_sync.sv | 21 ++
 rtl/gpio_edge_irq.sv | 69 ++++++
 tb/tb_gpio_edge_irq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_edge_irq_pkg.sv
// Shared definitions for the GPIO edge-interrupt block: register offsets and bus request shape.
package gpio_edge_irq_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] GPIO_IRQ_IN   = 2'd0;
  localparam logic [1:0] GPIO_IRQ_RISE = 2'd1;
  localparam logic [1:0] GPIO_IRQ_FALL = 2'd2;
  localparam logic [1:0] GPIO_IRQ_STAT = 2'd3;

  typedef struct packed {
    logic             sel;
    logic             wr;
    logic [1:0]       reg_sel;
    logic [BUS_W-1:0] data;
  } bus_req_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous inputs; async reset to 0.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_edge_irq.sv
// Per-pin rising/falling edge capture into sticky W1C status with a single level irq.
import gpio_edge_irq_pkg::*;

module gpio_edge_irq #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chip_select,
  input  logic             write_enable,
  input  logic [3:0]       addr,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  input  logic [WIDTH-1:0] pins_in,
  output logic             irq
);

  bus_req_t         req;
  logic             wr_hit, rd_hit;
  logic [WIDTH-1:0] sync_q, prev_q, rise_en, fall_en, status;
  logic [WIDTH-1:0] clr, new_edge;
  logic             unused_bits;

  assign req         = '{sel: chip_select, wr: write_enable, reg_sel: addr[3:2], data: write_data};
  assign wr_hit      = req.sel & req.wr;
  assign rd_hit      = req.sel & ~req.wr;
  assign unused_bits = ^{addr[1:0], write_data};

  gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pins_in),
    .q   (sync_q)
  );

  assign clr      = (wr_hit && req.reg_sel == GPIO_IRQ_STAT) ? req.data[WIDTH-1:0] : '0;
  assign new_edge = (sync_q & ~prev_q & rise_en) | (~sync_q & prev_q & fall_en);

  // Set is OR-ed in after the clear so a same-cycle edge is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
    end else begin
      prev_q <= sync_q;
      status <= (status & ~clr) | new_edge;
      if (wr_hit && req.reg_sel == GPIO_IRQ_RISE) rise_en <= req.data[WIDTH-1:0];
      if (wr_hit && req.reg_sel == GPIO_IRQ_FALL) fall_en <= req.data[WIDTH-1:0];
    end
  end

  assign irq = |(status & (rise_en | fall_en));

  always_comb begin
    read_data = '0;
    if (rd_hit) begin
      case (req.reg_sel)
        GPIO_IRQ_IN:   read_data[WIDTH-1:0] = sync_q;
        GPIO_IRQ_RISE: read_data[WIDTH-1:0] = rise_en;
        GPIO_IRQ_FALL: read_data[WIDTH-1:0] = fall_en;
        default:       read_data[WIDTH-1:0] = status;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_edge_irq.sv
// Directed scenarios plus randomized traffic checked against a pin-history reference model.
module tb_gpio_edge_irq;

  localparam int W  = 32;
  localparam int SS = 2;

  logic          clk = 0;
  logic          rst = 0;
  logic          cs = 0, we = 0;
  logic [3:0]    addr = '0;
  logic [31:0]   wd = '0;
  logic [31:0]   rdata;
  logic [W-1:0]  pins = '1;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;

  gpio_edge_irq #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rst          (rst),
    .chip_select  (cs),
    .write_enable (we),
    .addr         (addr),
    .write_data   (wd),
    .read_data    (rdata),
    .pins_in      (pins),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Reference model: pin samples delayed through a history queue, edges from consecutive sync levels.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_prev, m_rise, m_fall, m_status;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist.delete();
      for (int i = 0; i < SS; i++) m_hist.push_back('0);
      m_prev = '0; m_rise = '0; m_fall = '0; m_status = '0;
    end else begin
      logic [W-1:0] lvl;
      lvl = m_hist[SS-1];
      for (int i = 0; i < W; i++) begin
        if (cs && we && addr[3:2] == 2'd3 && wd[i]) m_status[i] = 1'b0;
        if (lvl[i] && !m_prev[i] && m_rise[i]) m_status[i] = 1'b1;
        if (!lvl[i] && m_prev[i] && m_fall[i]) m_status[i] = 1'b1;
      end
      if (cs && we && addr[3:2] == 2'd1) m_rise = wd;
      if (cs && we && addr[3:2] == 2'd2) m_fall = wd;
      m_prev = lvl;
      m_hist.push_front(pins);
      void'(m_hist.pop_back());
    end
  end

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return m_hist[SS-1];
      2'd1:    return m_rise;
      2'd2:    return m_fall;
      default: return m_status;
    endcase
  endfunction

  function automatic logic model_irq();
    logic any = 1'b0;
    for (int i = 0; i < W; i++) if (m_status[i] && (m_rise[i] || m_fall[i])) any = 1'b1;
    return any;
  endfunction

  // Stimulus helpers; called at a negedge and return at a negedge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    cs = 1; we = 1; addr = a; wd = d;
    @(negedge clk);
    cs = 0; we = 0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    cs = 1; we = 0; addr = a;
    #1 d = rdata;
    cs = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    pins = '1;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 0;
    bus_read(4'h4, d); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_rise_en: got %h expected 0", d); end
    bus_read(4'h8, d); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_fall_en: got %h expected 0", d); end
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h expected 0", d); end
    bus_read(4'h0, d); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_in: got %h expected 0", d); end
    @(negedge clk);
    bus_read(4'h0, d); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL in_after_1: got %h expected 0", d); end
    @(negedge clk);
    bus_read(4'h0, d); vectors++;
    if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL in_after_2: got %h expected ffffffff", d); end
    repeat (3) begin
      @(negedge clk); vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq_after: got %b expected 0", irq); end
    end
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_high_pins_status: got %h expected 0", d); end
    pins = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rise();
    logic [31:0] d;
    bus_write(4'h4, 32'h1);
    pins[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus_read(4'hC, d); vectors++;
      if (d !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL rise_early_c%0d: got status %h irq %b expected 0/0", c, d, irq); end
    end
    @(negedge clk);
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h1 || irq !== 1'b1) begin miscompares++; $display("FAIL rise_capture: got status %h irq %b expected 1/1", d, irq); end
    bus_write(4'hC, 32'h1);
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL rise_w1c: got status %h irq %b expected 0/0", d, irq); end
  endtask

  task automatic test_fall_filter();
    logic [31:0] d;
    bus_write(4'h4, 32'h0);
    bus_write(4'h8, 32'h8000_0000);
    pins[31:30] = 2'b11;
    repeat (4) @(negedge clk);
    bus_write(4'hC, 32'hFFFF_FFFF);
    pins[31:30] = 2'b00;
    repeat (4) @(negedge clk);
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h8000_0000 || irq !== 1'b1) begin miscompares++; $display("FAIL fall_filter: got status %h irq %b expected 80000000/1", d, irq); end
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_write(4'h8, 32'h0);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(4'h4, 32'h4);
    pins[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cs = 1; we = 1; addr = 4'hC; wd = 32'h4;
    @(negedge clk);
    cs = 0; we = 0;
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h4 || irq !== 1'b1) begin miscompares++; $display("FAIL collision_set_wins: got status %h irq %b expected 4/1", d, irq); end
    bus_write(4'hC, 32'h4);
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL collision_clear: got %h expected 0", d); end
    bus_write(4'h4, 32'h0);
  endtask

  task automatic test_mask();
    logic [31:0] d;
    bus_write(4'h4, 32'h20);
    pins[5] = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h20 || irq !== 1'b1) begin miscompares++; $display("FAIL mask_capture: got status %h irq %b expected 20/1", d, irq); end
    bus_write(4'h4, 32'h0);
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h20 || irq !== 1'b0) begin miscompares++; $display("FAIL mask_disabled: got status %h irq %b expected 20/0", d, irq); end
    bus_write(4'h4, 32'h20);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL mask_reenable: got irq %b expected 1", irq); end
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_write(4'h4, 32'h0);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    pins[3:0] = 4'h0;
    repeat (3) @(negedge clk);
    bus_write(4'h4, 32'hF);
    pins[3:0] = 4'hF;
    repeat (3) @(negedge clk);
    bus_read(4'hC, d); vectors++;
    if (d !== 32'hF || irq !== 1'b1) begin miscompares++; $display("FAIL pend_before_rst: got status %h irq %b expected f/1", d, irq); end
    cs = 0; we = 0; addr = 4'hC;
    #1 vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL cs_low_read: got %h expected 0", rdata); end
    #1 rst = 1;
    #1 vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL async_rst_irq: got %b expected 0", irq); end
    bus_read(4'hC, d); vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL async_rst_status: got %h expected 0", d); end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cs = 0; we = 0;
      vectors++;
      if (irq !== model_irq()) begin miscompares++; $display("FAIL rand_irq n=%0d: got %b expected %b", n, irq, model_irq()); end
      if ($urandom_range(3) == 0) pins = $urandom & $urandom;
      case ($urandom_range(5))
        0, 1: begin
          addr = 4'($urandom);
          bus_read(addr, d); vectors++;
          if (d !== model_read(addr)) begin miscompares++; $display("FAIL rand_read n=%0d a=%h: got %h expected %h", n, addr, d, model_read(addr)); end
          cs = 1; we = 0;
        end
        2: begin cs = 1; we = 1; addr = 4'($urandom); wd = $urandom; end
        3: begin cs = 1; we = 1; addr = {2'd3, 2'($urandom)}; wd = $urandom; end
        default: ;
      endcase
    end
    @(negedge clk);
    cs = 0; we = 0;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall_filter();
    test_collision();
    test_mask();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
